pulse_channel_detector: RTL



---
 rtl/pulse_channel_detector.sv | 99 +++++++++
 1 files changed

// File: rtl/pulse_channel_detector.sv
// Recovers the 2-bit channel code of a 4-to-1 test-signal mux output by
// measuring the half-period of the selected signal (0, 1 Hz, 10 Hz or 1).
module pulse_channel_detector #(
   parameter int CLK_FREQ = 50000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sig_in,
   output logic [1:0] sel_out,
   output logic       valid
);

   localparam int N1      = CLK_FREQ / 2;
   localparam int N2      = CLK_FREQ / 20;
   localparam int TOL1    = N1 >> 3;
   localparam int TOL2    = N2 >> 3;
   localparam int TIMEOUT = CLK_FREQ;
   localparam int CW      = $clog2(CLK_FREQ + 1);

   localparam logic [CW:0]   LO1    = (CW+1)'(N1 - TOL1);
   localparam logic [CW:0]   HI1    = (CW+1)'(N1 + TOL1);
   localparam logic [CW:0]   LO2    = (CW+1)'(N2 - TOL2);
   localparam logic [CW:0]   HI2    = (CW+1)'(N2 + TOL2);
   localparam logic [CW-1:0] TMO    = CW'(TIMEOUT);
   localparam logic [CW-1:0] TMO_M1 = CW'(TIMEOUT - 1);

   logic          s1, s2, s3;
   logic [CW-1:0] hp_cnt;
   logic          first;
   logic [1:0]    cand;
   logic          cand_ok;

   logic          sig_edge;
   logic [CW:0]   meas;
   logic [1:0]    cls;
   logic          cls_ok;

   assign sig_edge = s2 ^ s3;
   // hp_cnt restarts at 0 on each edge, so edge-to-edge distance is one more
   assign meas     = {1'b0, hp_cnt} + (CW+1)'(1);

   always_comb begin
      cls    = 2'b00;
      cls_ok = 1'b0;
      if (meas >= LO1 && meas <= HI1) begin
         cls    = 2'b01;
         cls_ok = 1'b1;
      end else if (meas >= LO2 && meas <= HI2) begin
         cls    = 2'b10;
         cls_ok = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1      <= 1'b0;
         s2      <= 1'b0;
         s3      <= 1'b0;
         hp_cnt  <= '0;
         first   <= 1'b1;
         cand    <= 2'b00;
         cand_ok <= 1'b0;
         sel_out <= 2'b00;
         valid   <= 1'b0;
      end else begin
         s1 <= sig_in;
         s2 <= s1;
         s3 <= s2;
         if (sig_edge) begin
            hp_cnt <= '0;
            if (first) begin
               first <= 1'b0;
            end else if (cls_ok) begin
               if (cand_ok && cls == cand) begin
                  sel_out <= cls;
                  valid   <= 1'b1;
               end else begin
                  cand    <= cls;
                  cand_ok <= 1'b1;
               end
            end else begin
               cand_ok <= 1'b0;
               valid   <= 1'b0;
            end
         end else begin
            if (hp_cnt != TMO)
               hp_cnt <= hp_cnt + CW'(1);
            // Counter saturates past this value, so the timeout fires only once
            if (hp_cnt == TMO_M1) begin
               sel_out <= {s2, s2};
               valid   <= 1'b1;
               cand_ok <= 1'b0;
               first   <= 1'b1;
            end
         end
      end
   end

endmodule
